// File: rtl/rice_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rice_core_pkg
// Brief    : Shared execute-stage types: divide operation flags and divider FSM states.
// Revision : 1.0
// ============================================================================
package rice_core_pkg;

  // One-hot-ish flag set from decode; bit 3 is div, bit 0 is remu.
  typedef struct packed {
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } rice_core_div_operation;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rice_core_div_state;

endpackage
`default_nettype wire

// File: rtl/rice_core_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : rice_core_div_unit
// Brief    : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Revision : 1.0
// ============================================================================
module rice_core_div_unit
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  rice_core_div_operation i_div_operation,
  input  logic [XLEN-1:0]        i_rs1_value,
  input  logic [XLEN-1:0]        i_rs2_value,
  input  logic                   i_flush,
  output logic                   o_result_valid,
  input  logic                   i_result_ready,
  output logic [XLEN-1:0]        o_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(XLEN - 1);

  rice_core_div_state r_state, w_next_state;

  logic             r_is_signed;
  logic             r_want_rem;
  logic             r_sign1;
  logic             r_sign2;
  logic             r_special;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN:0]    r_rem;

  logic            w_accept;
  logic            w_is_signed;
  logic            w_want_rem;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN:0]   w_rem_shift;
  logic            w_ge;
  logic [XLEN:0]   w_rem_next;
  logic [XLEN-1:0] w_quo_fixed;
  logic [XLEN-1:0] w_rem_fixed;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

  // Priority div > divu > rem > remu when several flags are set.
  assign w_is_signed = i_div_operation.div | (~i_div_operation.divu & i_div_operation.rem);
  assign w_want_rem  = ~i_div_operation.div & ~i_div_operation.divu &
                       (i_div_operation.rem | i_div_operation.remu);

  assign w_accept   = (r_state == IDLE) && i_valid && !i_flush && (|i_div_operation);
  assign w_div_zero = (i_rs2_value == '0);
  assign w_overflow = w_is_signed && (i_rs1_value == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (i_rs2_value == '1);
  assign w_mag1     = magnitude(i_rs1_value, w_is_signed);
  assign w_mag2     = magnitude(i_rs2_value, w_is_signed);

  // The remainder never exceeds the divisor, so its top bit is shifted out as zero.
  assign w_rem_shift = (r_rem << 1) | {{XLEN{1'b0}}, r_quo[XLEN-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_divisor}) : w_rem_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (w_div_zero || w_overflow) ? DONE : BUSY;
      BUSY:    if (r_count == C_LAST_STEP) w_next_state = DONE;
      DONE:    if (i_result_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (i_flush) w_next_state = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_signed <= 1'b0;
      r_want_rem  <= 1'b0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_special   <= 1'b0;
      r_count     <= '0;
      r_divisor   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
    end else if (w_accept) begin
      r_is_signed <= w_is_signed;
      r_want_rem  <= w_want_rem;
      r_sign1     <= i_rs1_value[XLEN-1];
      r_sign2     <= i_rs2_value[XLEN-1];
      r_special   <= w_div_zero | w_overflow;
      r_count     <= '0;
      r_divisor   <= w_mag2;
      if (w_div_zero) begin
        r_quo <= '1;
        r_rem <= {1'b0, i_rs1_value};
      end else if (w_overflow) begin
        r_quo <= {1'b1, {(XLEN-1){1'b0}}};
        r_rem <= '0;
      end else begin
        r_quo <= w_mag1;
        r_rem <= '0;
      end
    end else if (r_state == BUSY) begin
      r_quo   <= {r_quo[XLEN-2:0], w_ge};
      r_rem   <= w_rem_next;
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Special cases already hold their architectural results and skip sign correction.
  assign w_quo_fixed = (!r_special && r_is_signed && (r_sign1 ^ r_sign2)) ?
                       (~r_quo + XLEN'(1)) : r_quo;
  assign w_rem_fixed = (!r_special && r_is_signed && r_sign1) ?
                       (~r_rem[XLEN-1:0] + XLEN'(1)) : r_rem[XLEN-1:0];

  assign o_ready        = (r_state == IDLE);
  assign o_result_valid = (r_state == DONE);
  assign o_result       = (r_state != DONE) ? '0 : (r_want_rem ? w_rem_fixed : w_quo_fixed);

endmodule
`default_nettype wire
